timer_arbiter: RTL and testbench

Round-robin scheduler that shares the single 16-bit `timer` counter among N requesters that each need a timed interval. It latches the winning requester's limit, clears and enables the timer, watches `t_out`, and returns a one-cycle `done` pulse to the owner. It sits between the requesting FSMs and the `timer` instance and is the only driver of the timer's `t_en` and `reset` inputs.

---
 rtl/timer_arbiter.sv | 133 +++++++++++++
 tb/tb_timer_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin owner of a shared interval timer: grants one requester at a time,
// clears and runs the timer up to that requester's limit, then pulses done.
module timer_arbiter #(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] lim,
  input  logic [W-1:0]   t_out,
  input  logic           t_valid,
  output logic           t_en,
  output logic           t_clr,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [IW-1:0]  cur_id
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     cur_q, cur_d;
  logic [W-1:0]      lim_q, lim_d;
  logic              t_en_q, t_en_d;
  logic              t_clr_q, t_clr_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [N-1:0]      done_q, done_d;
  logic              busy_q, busy_d;

  logic [N-1:0][W-1:0] lim_a;
  logic [IW-1:0]       rr_sel;
  logic [IW-1:0]       nxt_id;
  logic [N-1:0]        oh_d;
  logic                unused_t_valid;

  assign unused_t_valid = t_valid;

  for (genvar i = 0; i < N; i++) begin : g_lim
    assign lim_a[i] = lim[i*W +: W];
  end

  // Walk offsets from the far end down so the nearest requester at/after ptr wins.
  always_comb begin
    int idx;
    idx    = 0;
    rr_sel = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (req[IW'(idx)]) rr_sel = IW'(idx);
    end
  end

  assign nxt_id = (cur_q == IW'(N-1)) ? '0 : cur_q + IW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    lim_d   = lim_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_CLEAR;
          cur_d   = rr_sel;
          lim_d   = lim_a[rr_sel];
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        // Owner dropping its request wins over a same-cycle match.
        if (!req[cur_q]) begin
          state_d = S_IDLE;
          ptr_d   = nxt_id;
        end else if (t_out == lim_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = nxt_id;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next state so they leave the flops aligned with it.
  assign oh_d = N'(1) << cur_d;

  always_comb begin
    t_en_d  = (state_d == S_RUN);
    t_clr_d = (state_d == S_CLEAR);
    busy_d  = (state_d != S_IDLE);
    grant_d = busy_d ? oh_d : '0;
    done_d  = (state_d == S_DONE) ? oh_d : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      lim_q   <= '0;
      t_en_q  <= 1'b0;
      t_clr_q <= 1'b1;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      lim_q   <= lim_d;
      t_en_q  <= t_en_d;
      t_clr_q <= t_clr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign t_en   = t_en_q;
  assign t_clr  = t_clr_q;
  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign cur_id = cur_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios plus randomized jobs against a
// transaction-level round-robin model, with a behavioural timer attached.
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] lim = '0;
  logic [W-1:0]   t_out;
  logic           t_valid = 1'b1;
  logic           t_en, t_clr, busy;
  logic [N-1:0]   grant, done;
  logic [1:0]     cur_id;

  logic [W-1:0]   tcnt;
  logic           ld = 1'b0;
  logic [W-1:0]   ld_val = '0;

  int tests = 0;
  int failed = 0;
  int ptr_m = 0;
  logic [10:0] exp_st;
  wire  [10:0] st = {grant, done, t_en, t_clr, busy};

  timer_arbiter #(.N(N), .W(W)) dut (
    .clock(clock), .reset(reset), .req(req), .lim(lim), .t_out(t_out),
    .t_valid(t_valid), .t_en(t_en), .t_clr(t_clr), .grant(grant),
    .done(done), .busy(busy), .cur_id(cur_id)
  );

  always #5 clock = ~clock;

  // Timer model: async clear, optional preload to reach the top of range quickly.
  always @(posedge clock or posedge t_clr) begin
    if (t_clr)      tcnt <= '0;
    else if (ld)    tcnt <= ld_val;
    else if (t_en)  tcnt <= tcnt + 1'b1;
  end
  assign t_out = tcnt;

  function automatic logic [10:0] mk(input logic [3:0] g, input logic [3:0] d,
                                     input logic en, input logic clr, input logic b);
    return {g, d, en, clr, b};
  endfunction

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[2'((p + k) % N)]) return (p + k) % N;
    return -1;
  endfunction

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic setlim(input int i, input logic [W-1:0] v);
    lim[i*W +: W] = v;
  endtask

  task automatic test_reset;
    #12;
    exp_st = mk(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL reset_outputs got=%b exp=%b", st, exp_st); end
    tests++; if (cur_id !== 2'd0) begin failed++; $display("FAIL reset_cur_id got=%0d exp=0", cur_id); end
    @(posedge clock); #1 reset = 1'b1;
    tick;
    exp_st = mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL reset_release got=%b exp=%b", st, exp_st); end
    ptr_m = 0;
  endtask

  task automatic test_single;
    setlim(0, 16'd3); req = 4'b0001;
    tick;
    exp_st = mk(4'b0001, 4'h0, 1'b0, 1'b1, 1'b1);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL single_clear got=%b exp=%b", st, exp_st); end
    for (int c = 0; c < 4; c++) begin
      tick;
      exp_st = mk(4'b0001, 4'h0, 1'b1, 1'b0, 1'b1);
      tests++; if (st !== exp_st) begin failed++; $display("FAIL single_run got=%b exp=%b", st, exp_st); end
      tests++; if (t_out !== 16'(c)) begin failed++; $display("FAIL single_tout got=%0d exp=%0d", t_out, c); end
    end
    tick;
    exp_st = mk(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL single_done got=%b exp=%b", st, exp_st); end
    req = 4'b0000;
    tick;
    exp_st = mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL single_idle got=%b exp=%b", st, exp_st); end
    tests++; if (t_out !== 16'd4) begin failed++; $display("FAIL single_hold got=%0d exp=4", t_out); end
    ptr_m = 1;
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    reset = 1'b0; tick; reset = 1'b1;
    for (int i = 0; i < N; i++) setlim(i, 16'd1);
    req = 4'hF;
    for (int j = 0; j < 5; j++) begin
      tick;
      exp_st = mk(oh(order[j]), 4'h0, 1'b0, 1'b1, 1'b1);
      tests++; if (st !== exp_st) begin failed++; $display("FAIL rr_clear job%0d got=%b exp=%b", j, st, exp_st); end
      for (int c = 0; c < 2; c++) begin
        tick;
        exp_st = mk(oh(order[j]), 4'h0, 1'b1, 1'b0, 1'b1);
        tests++; if (st !== exp_st) begin failed++; $display("FAIL rr_run job%0d got=%b exp=%b", j, st, exp_st); end
      end
      tick;
      exp_st = mk(oh(order[j]), oh(order[j]), 1'b0, 1'b0, 1'b1);
      tests++; if (st !== exp_st) begin failed++; $display("FAIL rr_done job%0d got=%b exp=%b", j, st, exp_st); end
      if (j == 4) req = 4'h0;
      tick;
      exp_st = mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      tests++; if (st !== exp_st) begin failed++; $display("FAIL rr_idle job%0d got=%b exp=%b", j, st, exp_st); end
    end
    ptr_m = 1;
  endtask

  task automatic test_limits;
    setlim(2, 16'd0); req = 4'b0100;
    tick;
    exp_st = mk(4'b0100, 4'h0, 1'b0, 1'b1, 1'b1);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL zero_clear got=%b exp=%b", st, exp_st); end
    tick;
    exp_st = mk(4'b0100, 4'h0, 1'b1, 1'b0, 1'b1);
    tests++; if (st !== exp_st || t_out !== 16'd0) begin failed++; $display("FAIL zero_run got=%b/%0d exp=%b/0", st, t_out, exp_st); end
    tick;
    exp_st = mk(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL zero_done got=%b exp=%b", st, exp_st); end
    req = 4'h0; tick;
    setlim(3, 16'hFFFF); req = 4'b1000;
    tick;
    exp_st = mk(4'b1000, 4'h0, 1'b0, 1'b1, 1'b1);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL max_clear got=%b exp=%b", st, exp_st); end
    tick;
    ld_val = 16'hFFFD; ld = 1'b1;
    tick;
    ld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      exp_st = mk(4'b1000, 4'h0, 1'b1, 1'b0, 1'b1);
      tests++; if (st !== exp_st || t_out !== 16'(16'hFFFD + c)) begin failed++; $display("FAIL max_run got=%b/%h exp=%b/%h", st, t_out, exp_st, 16'(16'hFFFD + c)); end
      tick;
    end
    exp_st = mk(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL max_done got=%b exp=%b", st, exp_st); end
    req = 4'h0; tick;
    ptr_m = 0;
  endtask

  task automatic test_abort;
    setlim(1, 16'd10); req = 4'b0010;
    tick;
    exp_st = mk(4'b0010, 4'h0, 1'b0, 1'b1, 1'b1);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL abort_clear got=%b exp=%b", st, exp_st); end
    tick; tick; tick;
    req = 4'b1001; setlim(3, 16'd2);
    tick;
    exp_st = mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL abort_idle got=%b exp=%b", st, exp_st); end
    tick;
    exp_st = mk(4'b1000, 4'h0, 1'b0, 1'b1, 1'b1);
    tests++; if (st !== exp_st || cur_id !== 2'd3) begin failed++; $display("FAIL abort_next_grant got=%b/%0d exp=%b/3", st, cur_id, exp_st); end
    tick; tick; tick; tick;
    exp_st = mk(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL abort_next_done got=%b exp=%b", st, exp_st); end
    req = 4'h0; tick;
    ptr_m = 0;
  endtask

  task automatic test_lim_change;
    setlim(0, 16'd5); req = 4'b0001;
    tick; tick;
    setlim(0, 16'd2);
    for (int c = 1; c <= 5; c++) begin
      tick;
      exp_st = mk(4'b0001, 4'h0, 1'b1, 1'b0, 1'b1);
      tests++; if (st !== exp_st || t_out !== 16'(c)) begin failed++; $display("FAIL limchg_run got=%b/%0d exp=%b/%0d", st, t_out, exp_st, c); end
    end
    tick;
    exp_st = mk(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL limchg_done got=%b exp=%b", st, exp_st); end
    req = 4'h0; tick;
    ptr_m = 1;
  endtask

  task automatic test_reset_mid;
    setlim(1, 16'd10); req = 4'b0010;
    tick;
    for (int c = 0; c < 5; c++) tick;
    #2 reset = 1'b0;
    #1;
    exp_st = mk(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    tests++; if (st !== exp_st || t_out !== 16'd0 || cur_id !== 2'd0) begin failed++; $display("FAIL rstmid_async got=%b/%0d/%0d exp=%b/0/0", st, t_out, cur_id, exp_st); end
    req = 4'b1000; setlim(3, 16'd1);
    @(posedge clock); #1 reset = 1'b1;
    ptr_m = 0;
    tick;
    exp_st = mk(4'b1000, 4'h0, 1'b0, 1'b1, 1'b1);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL rstmid_regrant got=%b exp=%b", st, exp_st); end
    tick;
    tests++; if (t_out !== 16'd0 || t_en !== 1'b1) begin failed++; $display("FAIL rstmid_tout got=%0d/%b exp=0/1", t_out, t_en); end
    tick; tick;
    exp_st = mk(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1);
    tests++; if (st !== exp_st) begin failed++; $display("FAIL rstmid_done got=%b exp=%b", st, exp_st); end
    req = 4'h0; tick;
    ptr_m = 0;
  endtask

  task automatic test_back_to_back_random;
    int own, el;
    logic [3:0] ohv;
    for (int j = 0; j < 40; j++) begin
      req = req | 4'($urandom_range(0, 15));
      if (req == 4'h0) req = oh(int'($urandom_range(0, 3)));
      for (int i = 0; i < N; i++) setlim(i, 16'($urandom_range(0, 6)));
      own = rr_pick(req, ptr_m);
      el  = int'(lim[own*W +: W]);
      ohv = oh(own);
      tick;
      exp_st = mk(ohv, 4'h0, 1'b0, 1'b1, 1'b1);
      tests++; if (st !== exp_st || cur_id !== 2'(own)) begin failed++; $display("FAIL rand_clear job%0d got=%b/%0d exp=%b/%0d", j, st, cur_id, exp_st, own); end
      for (int c = 0; c <= el; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int i = 0; i < N; i++) setlim(i, 16'($urandom_range(0, 6)));
          req = req | (4'($urandom_range(0, 15)) & ~ohv);
        end
        tick;
        exp_st = mk(ohv, 4'h0, 1'b1, 1'b0, 1'b1);
        tests++; if (st !== exp_st || t_out !== 16'(c)) begin failed++; $display("FAIL rand_run job%0d got=%b/%0d exp=%b/%0d", j, st, t_out, exp_st, c); end
      end
      tick;
      exp_st = mk(ohv, ohv, 1'b0, 1'b0, 1'b1);
      tests++; if (st !== exp_st) begin failed++; $display("FAIL rand_done job%0d got=%b exp=%b", j, st, exp_st); end
      if ($urandom_range(0, 1) == 1) req = req & ~ohv;
      ptr_m = (own + 1) % N;
      tick;
      exp_st = mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      tests++; if (st !== exp_st) begin failed++; $display("FAIL rand_idle job%0d got=%b exp=%b", j, st, exp_st); end
    end
    req = 4'h0; tick;
  endtask

  initial begin
    #1 reset = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_limits;
    test_abort;
    test_lim_change;
    test_reset_mid;
    test_back_to_back_random;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
